// File: rtl/mul_operand_sequencer.sv
// mul_operand_sequencer: valid/ready front end that feeds a successive-addition multiplier
// and returns its product, bypassing zero operands and timing out a silent multiplier.
module mul_operand_sequencer #(
   parameter int DW      = 4,
   parameter int PW      = 16,
   parameter int TIMEOUT = 40
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [DW-1:0] req_a,
   input  logic [DW-1:0] req_b,
   output logic          start,
   output logic [DW-1:0] din,
   input  logic          lda,
   input  logic          ldb,
   input  logic          done,
   input  logic [PW-1:0] prod,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [PW-1:0] rsp_prod,
   output logic          rsp_err,
   output logic          busy
);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, BYPASS, LAUNCH, RUN, RESP, DRAIN} state_t;

   state_t        state_q, state_d;
   logic [DW-1:0] a_q, a_d, b_q, b_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [PW-1:0] rsp_prod_q, rsp_prod_d;
   logic          rsp_err_q, rsp_err_d;
   logic          req_ready_q, req_ready_d;
   logic          start_q, start_d;
   logic          busy_q, busy_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic          expired;

   assign expired   = timer_q == TW'(TIMEOUT - 1);
   assign din       = lda ? a_q : ldb ? b_q : '0;
   assign req_ready = req_ready_q;
   assign start     = start_q;
   assign busy      = busy_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_prod  = rsp_prod_q;
   assign rsp_err   = rsp_err_q;

   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      timer_d    = timer_q;
      rsp_prod_d = rsp_prod_q;
      rsp_err_d  = rsp_err_q;
      case (state_q)
         IDLE: if (req_valid) begin
            a_d     = req_a;
            b_d     = req_b;
            timer_d = '0;
            state_d = (req_a == '0 || req_b == '0) ? BYPASS : LAUNCH;
         end
         BYPASS: begin
            rsp_prod_d = '0;
            rsp_err_d  = 1'b0;
            state_d    = RESP;
         end
         // the timeout outranks a late lda so a launch never outlives TIMEOUT
         LAUNCH: begin
            timer_d = timer_q + TW'(1);
            if (expired) begin
               rsp_prod_d = '0;
               rsp_err_d  = 1'b1;
               state_d    = RESP;
            end else if (lda) begin
               state_d = RUN;
            end
         end
         RUN: begin
            timer_d = timer_q + TW'(1);
            if (done) begin
               rsp_prod_d = prod;
               rsp_err_d  = 1'b0;
               state_d    = RESP;
            end else if (expired) begin
               rsp_prod_d = '0;
               rsp_err_d  = 1'b1;
               state_d    = RESP;
            end
         end
         RESP: if (rsp_ready) state_d = done ? DRAIN : IDLE;
         DRAIN: if (!done) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      req_ready_d = state_d == IDLE;
      start_d     = state_d == LAUNCH;
      busy_d      = state_d != IDLE;
      rsp_valid_d = state_d == RESP;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         timer_q     <= '0;
         rsp_prod_q  <= '0;
         rsp_err_q   <= 1'b0;
         req_ready_q <= 1'b1;
         start_q     <= 1'b0;
         busy_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         timer_q     <= timer_d;
         rsp_prod_q  <= rsp_prod_d;
         rsp_err_q   <= rsp_err_d;
         req_ready_q <= req_ready_d;
         start_q     <= start_d;
         busy_q      <= busy_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end
endmodule

// File: tb/tb_mul_operand_sequencer.sv
// tb_mul_operand_sequencer: drives mul_operand_sequencer against a behavioural multiplier
// and checks every cycle against a transaction-level timing model.
module tb_mul_operand_sequencer;
   localparam int DW = 4, PW = 16, TIMEOUT = 40;

   logic          clk = 1'b0, rst_n = 1'b1;
   logic          req_valid = 1'b0, rsp_ready = 1'b0, lda = 1'b0, ldb = 1'b0, done = 1'b0;
   logic [DW-1:0] req_a = '0, req_b = '0;
   logic [PW-1:0] prod = '0;
   logic          req_ready, start, rsp_valid, rsp_err, busy;
   logic [DW-1:0] din;
   logic [PW-1:0] rsp_prod;
   int            checks = 0, errors = 0, cyc = 0;

   always #5 clk = ~clk;

   mul_operand_sequencer #(.DW(DW), .PW(PW), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .start(start), .din(din), .lda(lda), .ldb(ldb),
      .done(done), .prod(prod), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_prod(rsp_prod), .rsp_err(rsp_err), .busy(busy)
   );

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at cycle %0d", nm, got, exp, cyc);
      end
   endtask

   // behavioural multiplier: mode 0 normal, 1 never loads A, 2 never raises done
   int            st = 0, cnt = 0, dcnt = 0, lda_dly = 0, done_len = 2, stub_mode = 0;
   bit            ovr = 0;
   logic [DW-1:0] ra = '0, rb = '0;
   always @(negedge clk) begin
      if (!ovr) begin
         if (lda) ra = din;
         if (ldb) rb = din;
         lda = 1'b0;
         ldb = 1'b0;
         if (!rst_n) begin
            st = 0; cnt = 0; done = 1'b0;
         end else case (st)
            0: begin
               done = 1'b0;
               if (!start) cnt = 0;
               else if (stub_mode != 1) begin
                  if (cnt >= lda_dly) begin lda = 1'b1; st = 1; cnt = 0; end
                  else cnt++;
               end
            end
            1: begin ldb = 1'b1; st = 2; cnt = 0; end
            2: begin
               prod = PW'($urandom);
               if (cnt == int'(rb)) begin
                  if (stub_mode == 2) st = 4;
                  else begin done = 1'b1; prod = PW'(ra) * PW'(rb); st = 3; dcnt = 1; end
               end else cnt++;
            end
            3: begin
               prod = PW'($urandom);
               if (dcnt >= done_len) begin done = 1'b0; st = 0; end
               else dcnt++;
            end
            default: if (!busy) st = 0;
         endcase
      end
   end

   // transaction-level model: ages a request from its accept edge
   bit            m_pend = 0, m_byp = 0, m_lda = 0, m_rsp = 0, m_drain = 0, m_e = 0;
   int            m_age = 0;
   logic [DW-1:0] m_a = '0, m_b = '0;
   logic [PW-1:0] m_p = '0;
   int            t_acc = 0, t_start = 0, t_rsp = 0, t_done = 0;
   bit            p_start = 0, p_rv = 0, p_done = 0;
   logic [DW-1:0] d_lda = '0, d_ldb = '0;
   always @(posedge clk) begin
      cyc++;
      #1;
      if (!rst_n) begin
         m_pend = 0; m_byp = 0; m_lda = 0; m_rsp = 0; m_drain = 0; m_e = 0;
         m_a = '0; m_b = '0; m_p = '0; m_age = 0;
      end else if (m_rsp) begin
         if (rsp_ready) begin
            chk("sb_prod", rsp_prod, (m_e || m_byp) ? 32'd0 : 32'(m_a) * 32'(m_b));
            m_rsp = 0;
            if (done) m_drain = 1; else m_pend = 0;
         end
      end else if (m_drain) begin
         if (!done) begin m_drain = 0; m_pend = 0; end
      end else if (m_pend) begin
         if (m_byp) begin m_rsp = 1; m_p = '0; m_e = 0; end
         else if (!m_lda) begin
            if (m_age == TIMEOUT - 1) begin m_rsp = 1; m_p = '0; m_e = 1; end
            else if (lda) m_lda = 1;
         end else if (done) begin m_rsp = 1; m_p = prod; m_e = 0; end
         else if (m_age == TIMEOUT - 1) begin m_rsp = 1; m_p = '0; m_e = 1; end
         m_age++;
      end else if (req_valid) begin
         m_pend = 1; m_age = 0; m_a = req_a; m_b = req_b; m_lda = 0;
         m_byp = (req_a == '0 || req_b == '0);
         t_acc = cyc - 1;
      end
      chk("req_ready", req_ready, !m_pend);
      chk("busy", busy, m_pend);
      chk("start", start, m_pend && !m_byp && !m_lda && !m_rsp && !m_drain);
      chk("rsp_valid", rsp_valid, m_rsp);
      chk("rsp_prod", rsp_prod, m_p);
      chk("rsp_err", rsp_err, m_e);
      chk("din", din, lda ? m_a : ldb ? m_b : '0);
      if (start && !p_start) t_start = cyc;
      if (rsp_valid && !p_rv) t_rsp = cyc;
      if (done && !p_done) t_done = cyc - 1;
      if (lda && !ovr) d_lda = din;
      if (ldb && !ovr) d_ldb = din;
      p_start = start; p_rv = rsp_valid; p_done = done;
   end

   task automatic txn(input logic [DW-1:0] a, input logic [DW-1:0] b, input int hold,
                      input bit noise, output logic [PW-1:0] p, output bit e);
      int n;
      @(negedge clk);
      req_a = a; req_b = b; req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 300) begin @(negedge clk); n++; end
      chk("accept_wait", n < 300, 1);
      @(negedge clk);
      req_valid = 1'b0;
      n = 0;
      while (!rsp_valid && n < 300) begin @(negedge clk); n++; end
      chk("rsp_wait", rsp_valid, 1);
      for (int i = 0; i < hold; i++) begin
         if (noise) begin req_valid = 1'b1; req_a = DW'($urandom); req_b = DW'($urandom); end
         @(negedge clk);
      end
      req_valid = 1'b0;
      p = rsp_prod;
      e = rsp_err;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [PW-1:0] p;
      bit            e;
      int            ts;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_req_ready", req_ready, 1);
      chk("rst_busy", busy, 0);
      rst_n = 1'b1;

      stub_mode = 0; lda_dly = 0; done_len = 2;
      txn(3, 2, 0, 0, p, e);
      chk("t1_prod", p, 6);
      chk("t1_err", e, 0);
      chk("t1_start_lat", t_start - t_acc, 1);
      chk("t1_rsp_lat", t_rsp - t_done, 1);
      chk("t1_din_lda", d_lda, 3);
      chk("t1_din_ldb", d_ldb, 2);

      repeat (3) @(negedge clk);
      ovr = 1; lda = 1'b1; ldb = 1'b1;
      #1 chk("din_both", din, 3);
      @(negedge clk); lda = 1'b0;
      #1 chk("din_ldb", din, 2);
      @(negedge clk); ldb = 1'b0; ovr = 0;
      #1 chk("din_none", din, 0);

      lda_dly = 2;
      txn(15, 15, 0, 0, p, e);
      chk("t2_prod", p, 16'h00E1);
      chk("t2_in_time", t_rsp - t_start <= TIMEOUT, 1);

      ts = t_start;
      txn(7, 0, 0, 0, p, e);
      chk("t3a_prod", p, 0);
      chk("t3a_err", e, 0);
      chk("t3a_lat", t_rsp - t_acc, 2);
      chk("t3a_nostart", t_start, ts);
      txn(0, 9, 0, 0, p, e);
      chk("t3b_prod", p, 0);
      chk("t3b_lat", t_rsp - t_acc, 2);
      chk("t3b_nostart", t_start, ts);

      lda_dly = 0; done_len = 12;
      txn(5, 4, 5, 1, p, e);
      chk("t4_prod", p, 20);
      chk("t4_err", e, 0);
      repeat (12) @(negedge clk);
      chk("t4_idle", req_ready, 1);

      done_len = 2;
      @(negedge clk);
      req_a = 9; req_b = 6; req_valid = 1'b1;
      @(negedge clk); req_valid = 1'b0;
      repeat (4) @(negedge clk);
      chk("t6_busy_before", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_start", start, 0);
      chk("t6_busy", busy, 0);
      chk("t6_rsp_valid", rsp_valid, 0);
      chk("t6_rsp_prod", rsp_prod, 0);
      chk("t6_rsp_err", rsp_err, 0);
      chk("t6_req_ready", req_ready, 1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      txn(2, 3, 0, 0, p, e);
      chk("t6_prod", p, 6);

      stub_mode = 2;
      txn(6, 3, 0, 0, p, e);
      chk("t5a_err", e, 1);
      chk("t5a_prod", p, 0);
      chk("t5a_lat", t_rsp - t_start, TIMEOUT);
      stub_mode = 1;
      txn(2, 2, 0, 0, p, e);
      chk("t5b_err", e, 1);
      chk("t5b_lat", t_rsp - t_start, TIMEOUT);

      for (int k = 0; k < 120; k++) begin
         logic [DW-1:0] a, b;
         a = ($urandom_range(0, 5) == 0) ? '0 : DW'($urandom);
         b = ($urandom_range(0, 5) == 0) ? '0 : DW'($urandom);
         stub_mode = ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, 2)) : 0;
         lda_dly = int'($urandom_range(0, 3));
         done_len = int'($urandom_range(1, 6));
         txn(a, b, int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)), p, e);
         if (a == '0 || b == '0) begin
            chk("rnd_byp_prod", p, 0); chk("rnd_byp_err", e, 0);
         end else if (stub_mode != 0) begin
            chk("rnd_to_prod", p, 0); chk("rnd_to_err", e, 1);
         end else begin
            chk("rnd_prod", p, 32'(a) * 32'(b)); chk("rnd_err", e, 0);
         end
      end
      stub_mode = 0;
      repeat (10) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
